// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared definitions for the lfsr block.
//                - maximal-length Fibonacci tap masks for widths 3..32
//                - default post-reset state
//                - next-state source selector used by the top-level mux
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    // Supported register widths for the tap table below.
    localparam int LFSR_MIN_WIDTH = 3;
    localparam int LFSR_MAX_WIDTH = 32;

    // Post-reset state; any non-zero value keeps the register off the
    // all-zero lock-up state.
    localparam logic [31:0] LFSR_DEFAULT_RESET_VALUE = 32'h0000_0001;

    // Where the next register value comes from on a clock edge.
    typedef enum logic [1:0] {
        NXT_SHIFT       = 2'd0,   // normal Fibonacci shift
        NXT_SEED        = 2'd1,   // synchronous seed load
        NXT_RESET_VALUE = 2'd2    // recovery to the reset state (zero guard)
    } lfsr_next_src_e;

    // Maximal-length tap masks. Bit i set means state bit i feeds the XOR.
    // A polynomial term x^k maps to mask bit k-1 (the shift moves data
    // from bit 0 toward bit WIDTH-1, so bit WIDTH-1 is always a tap).
    // Widths outside the supported range return an empty mask.
    function automatic logic [31:0] lfsr_max_taps(input int width);
        logic [31:0] taps;
        taps = 32'h0000_0000;
        if (width >= LFSR_MIN_WIDTH && width <= LFSR_MAX_WIDTH) begin
            case (width)
                3:       taps = 32'h0000_0006;   // x^3+x^2+1
                4:       taps = 32'h0000_000C;   // x^4+x^3+1
                5:       taps = 32'h0000_0014;   // x^5+x^3+1
                6:       taps = 32'h0000_0030;   // x^6+x^5+1
                7:       taps = 32'h0000_0060;   // x^7+x^6+1
                8:       taps = 32'h0000_00B8;   // x^8+x^6+x^5+x^4+1
                9:       taps = 32'h0000_0110;   // x^9+x^5+1
                10:      taps = 32'h0000_0240;   // x^10+x^7+1
                11:      taps = 32'h0000_0500;   // x^11+x^9+1
                12:      taps = 32'h0000_0829;   // x^12+x^6+x^4+x^1+1
                13:      taps = 32'h0000_100D;   // x^13+x^4+x^3+x^1+1
                14:      taps = 32'h0000_2015;   // x^14+x^5+x^3+x^1+1
                15:      taps = 32'h0000_6000;   // x^15+x^14+1
                16:      taps = 32'h0000_D008;   // x^16+x^15+x^13+x^4+1
                17:      taps = 32'h0001_2000;   // x^17+x^14+1
                18:      taps = 32'h0002_0400;   // x^18+x^11+1
                19:      taps = 32'h0004_0023;   // x^19+x^6+x^2+x^1+1
                20:      taps = 32'h0009_0000;   // x^20+x^17+1
                21:      taps = 32'h0014_0000;   // x^21+x^19+1
                22:      taps = 32'h0030_0000;   // x^22+x^21+1
                23:      taps = 32'h0042_0000;   // x^23+x^18+1
                24:      taps = 32'h00E1_0000;   // x^24+x^23+x^22+x^17+1
                25:      taps = 32'h0120_0000;   // x^25+x^22+1
                26:      taps = 32'h0200_0023;   // x^26+x^6+x^2+x^1+1
                27:      taps = 32'h0400_0013;   // x^27+x^5+x^2+x^1+1
                28:      taps = 32'h0900_0000;   // x^28+x^25+1
                29:      taps = 32'h1400_0000;   // x^29+x^27+1
                30:      taps = 32'h2000_0029;   // x^30+x^6+x^4+x^1+1
                31:      taps = 32'h4800_0000;   // x^31+x^28+1
                32:      taps = 32'h8020_0003;   // x^32+x^22+x^2+x^1+1
                default: taps = 32'h0000_0000;
            endcase
        end
        return taps;
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_feedback.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_feedback
//  Description : Combinational Fibonacci feedback bit: XOR-reduction of the
//                current state masked by the tap set.
//  Ports       : state  in  WIDTH  current LFSR state
//                fb     out 1      feedback bit shifted into bit 0
//  Parameters  : WIDTH  register width
//                TAPS   feedback mask (bit i set => state[i] participates)
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_feedback #(
    parameter int                WIDTH = 8,
    parameter logic [WIDTH-1:0]  TAPS  = 8'hB8
) (
    input  logic [WIDTH-1:0] state,
    output logic             fb
);

    logic [WIDTH-1:0] w_tapped;

    assign w_tapped = state & TAPS;
    assign fb       = ^w_tapped;

endmodule : lfsr_feedback
`default_nettype wire

// File: rtl/lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr
//  Description : Seedable Fibonacci LFSR producing a new pseudo-random
//                WIDTH-bit word every clock. Free-runs unless load is high;
//                load has priority over shifting.
//  Ports       : q     out WIDTH  current state (registered)
//                clk   in  1      rising-edge clock
//                rst   in  1      asynchronous reset, active low
//                seed  in  WIDTH  value captured while load is high
//                load  in  1      synchronous load enable
//  Parameters  : WIDTH        register width, 3..32
//                TAPS         feedback mask (defaults to a maximal-length set)
//                RESET_VALUE  post-reset state, must be non-zero
//  Build macro : LFSR_ZERO_GUARD_EN
//                  defined   - a zero seed loads RESET_VALUE instead, and an
//                              all-zero state recovers to RESET_VALUE on the
//                              next non-load edge.
//                  undefined - a zero seed loads zero and the register stays
//                              locked at zero until a non-zero load or reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr
    import lfsr_pkg::*;
#(
    parameter int                WIDTH       = 8,
    parameter logic [WIDTH-1:0]  TAPS        = WIDTH'(lfsr_max_taps(WIDTH)),
    parameter logic [WIDTH-1:0]  RESET_VALUE = WIDTH'(LFSR_DEFAULT_RESET_VALUE)
) (
    output logic [WIDTH-1:0] q,
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] seed,
    input  logic             load
);

    logic              w_fb;
    logic [WIDTH-1:0]  w_shifted;
    logic [WIDTH-1:0]  w_next;
    lfsr_next_src_e    w_src;

    // ------------------------------------------------------------------------
    // Feedback: purely combinational, no pipeline stage, so the shifted value
    // is available in the same cycle the state is presented.
    // ------------------------------------------------------------------------
    lfsr_feedback #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_feedback (
        .state (q),
        .fb    (w_fb)
    );

    assign w_shifted = {q[WIDTH-2:0], w_fb};

    // ------------------------------------------------------------------------
    // Next-state source selection. Load always wins over shifting; the zero
    // guard only redirects to RESET_VALUE, it never blocks a non-zero load.
    // ------------------------------------------------------------------------
    always_comb begin
        w_src = NXT_SHIFT;
        if (load) begin
            w_src = NXT_SEED;
        end
`ifdef LFSR_ZERO_GUARD_EN
        if (load && (seed == '0)) begin
            w_src = NXT_RESET_VALUE;
        end
        // All-zero state is a fixed point of the shift; kick it out.
        if (!load && (q == '0)) begin
            w_src = NXT_RESET_VALUE;
        end
`endif
    end

    always_comb begin
        w_next = w_shifted;
        case (w_src)
            NXT_SEED:        w_next = seed;
            NXT_RESET_VALUE: w_next = RESET_VALUE;
            default:         w_next = w_shifted;
        endcase
    end

    // ------------------------------------------------------------------------
    // State register. Reset takes effect immediately on assertion and holds
    // while low; the first edge after release performs a normal load/shift.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= RESET_VALUE;
        end else begin
            q <= w_next;
        end
    end

endmodule : lfsr
`default_nettype wire

// File: tb/tb_lfsr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lfsr
//  Description : Self-checking bench for lfsr (default 8-bit configuration).
//                Directed scenarios plus a randomized phase compared against
//                an arithmetic reference model of the polynomial recurrence.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr;

    localparam logic [7:0] C_TAPS  = 8'hB8;
    localparam logic [7:0] C_RESET = 8'h01;

    logic       clk;
    logic       clk_en;
    logic       rst;
    logic [7:0] seed;
    logic       load;
    logic [7:0] q;

    int n_checks;
    int n_fails;

    lfsr dut (
        .q    (q),
        .clk  (clk),
        .rst  (rst),
        .seed (seed),
        .load (load)
    );

    // Clock held idle until enabled so reset can be shown to act without it.
    initial begin
        clk = 1'b0;
        wait (clk_en);
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] observed,
                            input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference: next value of the recurrence s(n+1) = 2*s(n) + parity(taps)
    // modulo 256, with load and optional zero handling layered on top.
    function automatic logic [7:0] ref_next(input logic [7:0] cur,
                                            input logic ld,
                                            input logic [7:0] sd);
        int par;
        int v;
        if (ld) begin
`ifdef LFSR_ZERO_GUARD_EN
            if (sd == 8'h00) return C_RESET;
`endif
            return sd;
        end
`ifdef LFSR_ZERO_GUARD_EN
        if (cur == 8'h00) return C_RESET;
`endif
        par = $countones(cur & C_TAPS) % 2;
        v   = (int'(cur) * 2 + par) % 256;
        return 8'(v);
    endfunction

    // Advance one clock and land 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_q;
    bit         seen [256];

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clk_en   = 1'b0;
        rst      = 1'b1;
        load     = 1'b0;
        seed     = 8'h00;

        // 1. Reset acts without any clock.
        #2 rst = 1'b0;
        #1 check_eq("reset_no_clk", q, C_RESET);
        #2 rst = 1'b1;
        #1 check_eq("reset_release_hold", q, C_RESET);
        clk_en = 1'b1;

        // 2. Holding load keeps q at the seed.
        seed = 8'h05;
        load = 1'b1;
        for (int i = 0; i < 45; i++) begin
            step();
            check_eq("load_hold", q, 8'h05);
        end

        // 3. Known shift sequence after load drops.
        load = 1'b0;
        step(); check_eq("seq_0A", q, 8'h0A);
        step(); check_eq("seq_15", q, 8'h15);
        step(); check_eq("seq_2B", q, 8'h2B);
        step(); check_eq("seq_56", q, 8'h56);

        // 4. Full period from 0x01.
        #2 rst = 1'b0;
        #1 check_eq("reset_async", q, C_RESET);
        #2 rst = 1'b1;
        foreach (seen[k]) seen[k] = 1'b0;
        seen[1] = 1'b1;
        exp_q   = C_RESET;
        for (int i = 1; i <= 255; i++) begin
            step();
            exp_q = ref_next(exp_q, 1'b0, 8'h00);
            check_eq("period_seq", q, exp_q);
            if (i < 255) begin
                check_eq("period_no_zero", 32'(q == 8'h00), 32'd0);
                check_eq("period_no_repeat", 32'(seen[q]), 32'd0);
                seen[q] = 1'b1;
            end
        end
        check_eq("period_255", q, C_RESET);

        // 5. Zero seed.
        seed = 8'h00;
        load = 1'b1;
        step();
        load = 1'b0;
`ifdef LFSR_ZERO_GUARD_EN
        check_eq("zero_seed_guard", q, C_RESET);
        step();
        check_eq("zero_seed_guard_shift", q, 8'h02);
`else
        check_eq("zero_seed_load", q, 8'h00);
        step();
        check_eq("zero_lock_1", q, 8'h00);
        step();
        check_eq("zero_lock_2", q, 8'h00);
`endif

        // 6. Asynchronous reset mid-sequence, release mid-cycle.
        seed = 8'h5A;
        load = 1'b1;
        step();
        load = 1'b0;
        step(); step(); step();
        #2 rst = 1'b0;
        #1 check_eq("mid_reset", q, C_RESET);
        #2 rst = 1'b1;
        step();
        check_eq("mid_reset_resume_1", q, 8'h02);
        step();
        check_eq("mid_reset_resume_2", q, 8'h04);

        // 7. Randomized loads, seeds (including zero) and reset pulses.
        exp_q = q;
        for (int i = 0; i < 400; i++) begin
            load = ($urandom_range(0, 3) == 0);
            seed = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step();
            exp_q = ref_next(exp_q, load, seed);
            check_eq("rand_seq", q, exp_q);
            if ($urandom_range(0, 19) == 0) begin
                #2 rst = 1'b0;
                #1 check_eq("rand_reset", q, C_RESET);
                exp_q = C_RESET;
                #2 rst = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fails);
        $finish;
    end

endmodule : tb_lfsr
`default_nettype wire
